store_unit: RTL and testbench

Write-side counterpart of the load-extraction path. Takes a store request from the execute stage (sb, sh or sw, byte address, rt value) and steers the data onto the correct byte lanes with a matching byteenable. It drives a single Avalon-MM write on the data-memory port and holds it stable through waitrequest. It reports completion or misalignment back to the CPU control FSM, which stalls on `busy`.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/store_align.sv | 48 ++++
 rtl/store_unit.sv | 117 +++++++++++
 tb/tb_store_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the CPU memory paths: store/load width opcodes
// and the store unit state encoding.
package mips_pkg;

  // Width opcodes taken from instruction[28:26]; the load path decodes the same field.
  localparam logic [2:0] OP_SB = 3'b000;
  localparam logic [2:0] OP_SH = 3'b001;
  localparam logic [2:0] OP_SW = 3'b011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RESP  = 2'd2
  } store_state_t;

  // True for the three width codes the store path understands.
  function automatic logic is_store_op(input logic [2:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/store_align.sv
// Combinational lane steering for stores: replicates the source bytes
// across the word and picks the byteenable for the addressed lanes.
// Lane k is byte offset k (little-endian, same as the load path).
module store_align
  import mips_pkg::*;
(
  input  logic [2:0]  opcode,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rt_data,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic        misalign
);

  // Decode width and offset into lanes; misaligned or unknown widths enable no lanes.
  always_comb begin
    byteenable = 4'b0000;
    writedata  = 32'h0;
    misalign   = 1'b0;
    if (!is_store_op(opcode)) begin
      misalign = 1'b1;
    end else begin
      case (opcode)
        OP_SB: begin
          byteenable = 4'b0001 << addr_lo;
          writedata  = {4{rt_data[7:0]}};
        end
        OP_SH: begin
          if (addr_lo[0]) begin
            misalign = 1'b1;
          end else begin
            byteenable = addr_lo[1] ? 4'b1100 : 4'b0011;
            writedata  = {2{rt_data[15:0]}};
          end
        end
        default: begin
          if (addr_lo != 2'b00) begin
            misalign = 1'b1;
          end else begin
            byteenable = 4'b1111;
            writedata  = rt_data;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/store_unit.sv
// Store unit: accepts one sb/sh/sw request at a time from the CPU, issues a
// single Avalon-MM write with steered lanes, and reports done or misalign.
//
// Handshakes:
//   CPU side  - a request transfers on a rising edge where req=1 and ready=1;
//               req seen while ready=0 is ignored, so the CPU holds it.
//   Avalon    - the write transfers on a rising edge where avm_write=1 and
//               avm_waitrequest=0; address, data and byteenable come straight
//               from flops and cannot move while the slave stalls.
module store_unit
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic [31:0]       instruction,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       rt_data,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              misalign,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  output store_state_t      dbg_state
);

  store_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              misalign_q, misalign_d;

  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic              al_misalign;

  // Only the width field of the instruction matters here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instruction[31:29], instruction[25:0]};

  store_align u_align (
    .opcode     (instruction[28:26]),
    .addr_lo    (addr[1:0]),
    .rt_data    (rt_data),
    .byteenable (al_be),
    .writedata  (al_wdata),
    .misalign   (al_misalign)
  );

  // Next-state and capture logic: latch the steered write on accept, pulse misalign on reject.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    misalign_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (al_misalign) begin
            misalign_d = 1'b1;
          end else begin
            addr_d  = {addr[ADDR_W-1:2], 2'b00};
            wdata_d = al_wdata;
            be_d    = al_be;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (!avm_waitrequest) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and write-register flops; reset abandons any write in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      misalign_q <= misalign_d;
    end
  end

  assign ready          = (state_q == IDLE);
  assign busy           = !ready;
  assign done           = (state_q == RESP);
  assign misalign       = misalign_q;
  assign avm_write      = (state_q == WRITE);
  assign avm_address    = addr_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = be_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: drivers push expected writes and events
// into queues, a negedge monitor pops and compares them.
module tb_store_unit;
  import mips_pkg::*;

  localparam int W = 68;  // {address[31:0], byteenable[3:0], writedata[31:0]}
  localparam logic [1:0] EV_DONE = 2'b10;
  localparam logic [1:0] EV_MIS  = 2'b01;

  logic         clk;
  logic         reset_n;
  logic         req;
  logic [31:0]  instruction;
  logic [31:0]  addr;
  logic [31:0]  rt_data;
  logic         ready;
  logic         busy;
  logic         done;
  logic         misalign;
  logic [31:0]  avm_address;
  logic         avm_write;
  logic [31:0]  avm_writedata;
  logic [3:0]   avm_byteenable;
  logic         avm_waitrequest;
  store_state_t dbg_state;

  logic [W-1:0] exp_q[$];
  logic [1:0]   ev_q[$];
  int           checks;
  int           errors;

  store_unit #(.ADDR_W(32)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req             (req),
    .instruction     (instruction),
    .addr            (addr),
    .rt_data         (rt_data),
    .ready           (ready),
    .busy            (busy),
    .done            (done),
    .misalign        (misalign),
    .avm_address     (avm_address),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_waitrequest (avm_waitrequest),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] wr(input logic [31:0] a, input logic [3:0] be,
                                       input logic [31:0] d);
    return {a, be, d};
  endfunction

  function automatic logic [31:0] instr_of(input logic [2:0] op);
    logic [31:0] v;
    v = 32'h0;
    v[28:26] = op;
    v[31:29] = 3'b101;
    return v;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic         prev_stall;
  logic [W-1:0] prev_bus;

  always @(negedge clk) begin
    logic [W-1:0] cur;
    logic [W-1:0] e;
    logic [1:0]   ev;
    cur = wr(avm_address, avm_byteenable, avm_writedata);
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (avm_write && prev_stall)
        chk("bus_stable_in_stall", cur, prev_bus);
      if (avm_write && !avm_waitrequest) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", cur, '0);
        end else begin
          e = exp_q.pop_front();
          chk("write_beat", cur, e);
        end
      end
      if (done || misalign) begin
        chk("done_misalign_exclusive", W'(done && misalign), '0);
        if (ev_q.size() == 0) begin
          chk("unexpected_event", W'({done, misalign}), '0);
        end else begin
          ev = ev_q.pop_front();
          chk("event_kind", W'({done, misalign}), W'(ev));
        end
      end
      prev_stall = avm_write && avm_waitrequest;
      prev_bus   = cur;
    end
  end

  // ---------------- drivers ----------------
  // One aligned store; waits = number of waitrequest-high cycles in WRITE.
  task automatic do_store(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] d, input int waits, input logic [W-1:0] exp_w);
    int   k;
    logic seen;
    exp_q.push_back(exp_w);
    ev_q.push_back(EV_DONE);
    instruction     = instr_of(op);
    addr            = a;
    rt_data         = d;
    req             = 1'b1;
    avm_waitrequest = (waits > 0);
    @(posedge clk); #1;
    req  = 1'b0;
    k    = 1;
    seen = 1'b0;
    while (!seen && k < 60) begin
      avm_waitrequest = (k <= waits);
      @(negedge clk);
      if (k == 1) chk({name, "_write_in_n1"}, W'(avm_write), W'(1'b1));
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        k++;
      end
    end
    chk({name, "_done_latency"}, W'(k), W'(waits + 2));
    avm_waitrequest = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk({name, "_done_one_cycle"}, W'(done), '0);
    chk({name, "_ready_back"}, W'(ready), W'(1'b1));
    @(posedge clk); #1;
  endtask

  // Wait (bounded) for the edge that accepts the currently driven req; returns its time.
  task automatic wait_accept(input string name, output time t);
    int   n;
    logic r;
    n = 0;
    r = 1'b0;
    while (!r && n < 20) begin
      @(negedge clk);
      r = ready;
      @(posedge clk);
      n++;
    end
    t = $time;
    #1;
    if (!r) chk({name, "_accept_timeout"}, W'(n), '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    time t_acc[4];
    int  n;
    checks          = 0;
    errors          = 0;
    prev_stall      = 1'b0;
    prev_bus        = '0;
    reset_n         = 1'b0;
    req             = 1'b0;
    instruction     = 32'h0;
    addr            = 32'h0;
    rt_data         = 32'h0;
    avm_waitrequest = 1'b0;

    #12;
    chk("reset_ready", W'(ready), W'(1'b1));
    chk("reset_busy", W'(busy), '0);
    chk("reset_done_mis", W'({done, misalign}), '0);
    chk("reset_bus", W'({avm_write, avm_address, avm_byteenable, avm_writedata}), '0);
    chk("reset_state", W'(dbg_state), W'(IDLE));
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // sb to top byte, no wait states
    do_store("sb_1003", OP_SB, 32'h0000_1003, 32'h1234_56AB, 0,
             wr(32'h0000_1000, 4'b1000, 32'hABAB_ABAB));
    // sh upper half, three stall cycles
    do_store("sh_2002", OP_SH, 32'h0000_2002, 32'hDEAD_BEEF, 3,
             wr(32'h0000_2000, 4'b1100, 32'hBEEF_BEEF));
    // sw aligned
    do_store("sw_3000", OP_SW, 32'h0000_3000, 32'hCAFE_F00D, 0,
             wr(32'h0000_3000, 4'b1111, 32'hCAFE_F00D));
    // sh lower half, one stall cycle
    do_store("sh_6000", OP_SH, 32'h0000_6000, 32'h8765_4321, 1,
             wr(32'h0000_6000, 4'b0011, 32'h4321_4321));

    // misaligned sh, then misaligned sw issued in the pulse cycle
    instruction = instr_of(OP_SH);
    addr        = 32'h0000_4001;
    rt_data     = 32'h5555_AAAA;
    req         = 1'b1;
    ev_q.push_back(EV_MIS);
    @(posedge clk); #1;
    instruction = instr_of(OP_SW);
    addr        = 32'h0000_4002;
    ev_q.push_back(EV_MIS);
    @(negedge clk);
    chk("mis_sh_pulse", W'(misalign), W'(1'b1));
    chk("mis_sh_ready", W'(ready), W'(1'b1));
    chk("mis_sh_no_write", W'(avm_write), '0);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("mis_sw_pulse", W'(misalign), W'(1'b1));
    chk("mis_sw_no_write", W'(avm_write), '0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mis_pulse_ends", W'(misalign), '0);
    chk("mis_ready_held", W'(ready), W'(1'b1));
    @(posedge clk); #1;

    // undefined width code 010 is rejected
    instruction = instr_of(3'b010);
    addr        = 32'h0000_7000;
    req         = 1'b1;
    ev_q.push_back(EV_MIS);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("mis_badop_pulse", W'(misalign), W'(1'b1));
    chk("mis_badop_no_write", W'(avm_write), '0);
    @(posedge clk); #1;

    // back-to-back sb to offsets 0..3 with req held high
    rt_data     = 32'h1122_3344;
    instruction = instr_of(OP_SB);
    for (int i = 0; i < 4; i++) begin
      addr = 32'h0000_5000 + i;
      exp_q.push_back(wr(32'h0000_5000, 4'b0001 << i, 32'h4444_4444));
      ev_q.push_back(EV_DONE);
      req = 1'b1;
      wait_accept("b2b", t_acc[i]);
    end
    req = 1'b0;
    for (int i = 1; i < 4; i++)
      chk("b2b_spacing", W'(t_acc[i] - t_acc[i-1]), W'(30));
    n = 0;
    while (ev_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_all_done", W'(ev_q.size()), '0);
    @(posedge clk); #1;

    // reset in the middle of a stalled write
    instruction     = instr_of(OP_SW);
    addr            = 32'h0000_9000;
    rt_data         = 32'h1111_1111;
    avm_waitrequest = 1'b1;
    req             = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_write_before", W'(avm_write), W'(1'b1));
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_write_drop", W'(avm_write), '0);
    chk("rst_mid_ready", W'(ready), W'(1'b1));
    chk("rst_mid_bus_clear", W'({avm_address, avm_byteenable, avm_writedata}), '0);
    @(posedge clk); #1;
    reset_n         = 1'b1;
    avm_waitrequest = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_done", W'({done, misalign}), '0);
      @(posedge clk); #1;
    end
    do_store("sw_after_rst", OP_SW, 32'h0000_8004, 32'h0BAD_F00D, 2,
             wr(32'h0000_8004, 4'b1111, 32'h0BAD_F00D));

    repeat (2) @(posedge clk);
    #1;
    chk("exp_q_drained", W'(exp_q.size()), '0);
    chk("ev_q_drained", W'(ev_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
